// File: rtl/painterengine_gpu_reader_scheduler_pkg.sv
// Shared definitions for the PainterEngine GPU reader scheduler:
// state encoding, reader/scheduler error codes and channel count.
package painterengine_gpu_reader_scheduler_pkg;

   localparam int NUM_CH = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   // Codes 000-101 come from the reader; 110 is raised by the scheduler itself.
   localparam logic [2:0] ERR_NONE     = 3'b000;
   localparam logic [2:0] ERR_BUS      = 3'b001;
   localparam logic [2:0] ERR_ALIGN    = 3'b010;
   localparam logic [2:0] ERR_LENGTH   = 3'b011;
   localparam logic [2:0] ERR_FORMAT   = 3'b100;
   localparam logic [2:0] ERR_OVERFLOW = 3'b101;
   localparam logic [2:0] ERR_TIMEOUT  = 3'b110;

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] idx);
      ch_onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter.sv
// Combinational round-robin pick: first requester after the pointer wins.
module painterengine_gpu_rr_arbiter
   import painterengine_gpu_reader_scheduler_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  logic [1:0]        ptr_i,
   output logic [1:0]        idx_o,
   output logic              valid_o
);

   // Scan farthest-to-nearest so the nearest requester after ptr_i is written last.
   always_comb begin
      logic [1:0] cand;
      idx_o   = 2'd0;
      valid_o = 1'b0;
      cand    = 2'd0;
      for (int i = NUM_CH; i >= 1; i--) begin
         cand    = ptr_i + 2'(i);
         idx_o   = req_i[cand] ? cand : idx_o;
         valid_o = valid_o | req_i[cand];
      end
   end

endmodule

// File: rtl/painterengine_gpu_reader_scheduler.sv
// Time-multiplexes one GPU reader among four channels: per job it holds the
// reader in reset, runs it under a watchdog, and reports done/error per channel.
module painterengine_gpu_reader_scheduler
   import painterengine_gpu_reader_scheduler_pkg::*;
#(
   parameter int RESET_CYCLES    = 2,
   parameter int WATCHDOG_CYCLES = 1048576
)
(
   input  logic         i_wire_clock,
   input  logic         i_wire_reset,
   input  logic [3:0]   i_wire_request,
   input  logic [127:0] i_wire_address,
   input  logic [127:0] i_wire_length,
   output logic [3:0]   o_wire_grant,
   output logic [3:0]   o_wire_channel_done,
   output logic [3:0]   o_wire_channel_error,
   output logic [2:0]   o_wire_error_type,
   output logic         o_wire_busy,
   output logic         o_wire_reader_resetn,
   output logic [3:0]   o_wire_router,
   output logic [127:0] o_wire_address,
   output logic [127:0] o_wire_length,
   input  logic         i_wire_reader_done,
   input  logic         i_wire_reader_error,
   input  logic [2:0]   i_wire_reader_error_type
);

   localparam logic [15:0] HOLD_LAST  = 16'(RESET_CYCLES - 1);
   localparam logic [20:0] WDOG_LIMIT = 21'(WATCHDOG_CYCLES);

   logic [1:0]   state_q, state_d;
   logic [1:0]   idx_q, idx_d;
   logic [1:0]   last_q, last_d;
   logic [15:0]  hold_q, hold_d;
   logic [20:0]  wdog_q, wdog_d;
   logic [3:0]   grant_q, grant_d;
   logic [3:0]   router_q, router_d;
   logic         resetn_q, resetn_d;
   logic [127:0] addr_q, addr_d;
   logic [127:0] len_q, len_d;
   logic [3:0]   done_q, done_d;
   logic [3:0]   err_q, err_d;
   logic [2:0]   etype_q, etype_d;
   logic         busy_q, busy_d;
   logic [1:0]   win_idx_s;
   logic         win_valid_s;

   painterengine_gpu_rr_arbiter u_arb (
      .req_i   (i_wire_request),
      .ptr_i   (last_q),
      .idx_o   (win_idx_s),
      .valid_o (win_valid_s)
   );

   // Next-state and next-output computation for the job sequencer.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      hold_d   = hold_q;
      wdog_d   = wdog_q;
      grant_d  = grant_q;
      router_d = router_q;
      resetn_d = resetn_q;
      addr_d   = addr_q;
      len_d    = len_q;
      done_d   = 4'b0000;
      err_d    = 4'b0000;
      etype_d  = etype_q;
      case (state_q)
         ST_IDLE: begin
            resetn_d = 1'b0;
            addr_d   = 128'd0;
            len_d    = 128'd0;
            if (win_valid_s) begin
               state_d  = ST_HOLD;
               idx_d    = win_idx_s;
               grant_d  = ch_onehot(win_idx_s);
               router_d = ch_onehot(win_idx_s);
               hold_d   = 16'd0;
               wdog_d   = 21'd0;
               addr_d[{win_idx_s, 5'd0} +: 32] = i_wire_address[{win_idx_s, 5'd0} +: 32];
               len_d[{win_idx_s, 5'd0} +: 32]  = i_wire_length[{win_idx_s, 5'd0} +: 32];
            end else begin
               grant_d  = 4'b0000;
               router_d = 4'b0000;
            end
         end
         ST_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d  = ST_RUN;
               resetn_d = 1'b1;
            end else begin
               hold_d   = hold_q + 16'd1;
            end
         end
         ST_RUN: begin
            wdog_d = wdog_q + 21'd1;
            // Error outranks done; the watchdog only fires if the reader is silent.
            if (i_wire_reader_error) begin
               err_d   = ch_onehot(idx_q);
               etype_d = i_wire_reader_error_type;
            end else if (i_wire_reader_done) begin
               done_d  = ch_onehot(idx_q);
               last_d  = idx_q;
            end else if (wdog_d == WDOG_LIMIT) begin
               err_d   = ch_onehot(idx_q);
               etype_d = ERR_TIMEOUT;
            end else begin
               etype_d = etype_q;
            end
            if ((done_d | err_d) != 4'b0000) begin
               state_d  = ST_RELEASE;
               resetn_d = 1'b0;
               grant_d  = 4'b0000;
               router_d = 4'b0000;
               addr_d   = 128'd0;
               len_d    = 128'd0;
            end else begin
               resetn_d = 1'b1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            resetn_d = 1'b0;
            grant_d  = 4'b0000;
            router_d = 4'b0000;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         last_q   <= 2'd3;
         hold_q   <= 16'd0;
         wdog_q   <= 21'd0;
         grant_q  <= 4'b0000;
         router_q <= 4'b0000;
         resetn_q <= 1'b0;
         addr_q   <= 128'd0;
         len_q    <= 128'd0;
         done_q   <= 4'b0000;
         err_q    <= 4'b0000;
         etype_q  <= ERR_NONE;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         hold_q   <= hold_d;
         wdog_q   <= wdog_d;
         grant_q  <= grant_d;
         router_q <= router_d;
         resetn_q <= resetn_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         done_q   <= done_d;
         err_q    <= err_d;
         etype_q  <= etype_d;
         busy_q   <= busy_d;
      end
   end

   assign o_wire_grant         = grant_q;
   assign o_wire_router        = router_q;
   assign o_wire_reader_resetn = resetn_q;
   assign o_wire_address       = addr_q;
   assign o_wire_length        = len_q;
   assign o_wire_channel_done  = done_q;
   assign o_wire_channel_error = err_q;
   assign o_wire_error_type    = etype_q;
   assign o_wire_busy          = busy_q;

endmodule

// File: tb/tb_painterengine_gpu_reader_scheduler.sv
// Scoreboard bench for the reader scheduler with a behavioural reader model.
module tb_painterengine_gpu_reader_scheduler;

   localparam int RC = 2;
   localparam int WD = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [127:0] addr_bus, len_bus;
   logic [3:0]   o_grant, o_done, o_err, o_router;
   logic [2:0]   o_etype;
   logic         o_busy, o_resetn;
   logic [127:0] o_addr, o_len;
   logic         rd_done, rd_err;
   logic [2:0]   rd_etype;

   always #5 clk = ~clk;

   painterengine_gpu_reader_scheduler #(.RESET_CYCLES(RC), .WATCHDOG_CYCLES(WD)) dut (
      .i_wire_clock             (clk),
      .i_wire_reset             (rst),
      .i_wire_request           (req),
      .i_wire_address           (addr_bus),
      .i_wire_length            (len_bus),
      .o_wire_grant             (o_grant),
      .o_wire_channel_done      (o_done),
      .o_wire_channel_error     (o_err),
      .o_wire_error_type        (o_etype),
      .o_wire_busy              (o_busy),
      .o_wire_reader_resetn     (o_resetn),
      .o_wire_router            (o_router),
      .o_wire_address           (o_addr),
      .o_wire_length            (o_len),
      .i_wire_reader_done       (rd_done),
      .i_wire_reader_error      (rd_err),
      .i_wire_reader_error_type (rd_etype)
   );

   typedef struct {
      int       ch;
      bit       is_err;
      logic [2:0] etype;
      int       run_len;
   } exp_t;

   exp_t pq[$];
   int   gq[$];
   int   checks = 0, failures = 0;
   int   remaining[4];
   logic [31:0] ch_addr[4];
   logic [31:0] ch_len[4];
   int   done_after, err_after;
   logic [2:0] err_code;
   int   run_cnt, last_run, hold_cnt, cyc, req_cyc, fall_cyc, cur_ch;
   bit   lat_check, gap_check, have_fall;
   logic [3:0] prev_grant, cur_exp;
   logic [2:0] exp_etype;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] bus_of(input int ch, input logic [31:0] v);
      logic [127:0] b;
      b = '0;
      b[ch*32 +: 32] = v;
      return b;
   endfunction

   task automatic drive_inputs();
      for (int c = 0; c < 4; c++) begin
         req[c] = (remaining[c] > 0);
         addr_bus[c*32 +: 32] = ch_addr[c];
         len_bus[c*32 +: 32]  = ch_len[c];
      end
      rd_done  = o_resetn && (done_after != 0) && (run_cnt >= done_after);
      rd_err   = o_resetn && (err_after != 0) && (run_cnt >= err_after);
      rd_etype = err_code;
   endtask

   task automatic cycle();
      exp_t e;
      logic [3:0] oh;
      @(negedge clk);
      cyc++;
      if (o_grant != 4'b0000 && prev_grant == 4'b0000) begin
         if (gq.size() == 0) begin
            check_val("grant_unexpected", o_grant, 128'd0);
         end else begin
            cur_ch  = gq.pop_front();
            cur_exp = 4'b0001 << cur_ch;
            check_val("grant_order", o_grant, cur_exp);
            if (gap_check && have_fall) check_val("gap", cyc - fall_cyc, 2);
         end
      end
      if (o_grant == 4'b0000 && prev_grant != 4'b0000) begin
         fall_cyc  = cyc;
         have_fall = 1'b1;
      end
      if (o_grant != 4'b0000) begin
         check_val("grant_hold", o_grant, cur_exp);
         check_val("router", o_router, cur_exp);
      end
      prev_grant = o_grant;
      if (o_resetn) begin
         run_cnt++;
         if (run_cnt == 1) begin
            check_val("hold_len", hold_cnt, RC);
            hold_cnt = 0;
            check_val("addr_bus", o_addr, bus_of(cur_ch, ch_addr[cur_ch]));
            check_val("len_bus", o_len, bus_of(cur_ch, ch_len[cur_ch]));
            if (lat_check) begin
               check_val("latency", cyc - req_cyc, 1 + RC);
               lat_check = 1'b0;
            end
         end
      end else begin
         if (run_cnt != 0) last_run = run_cnt;
         run_cnt = 0;
         if (o_grant != 4'b0000) hold_cnt++;
      end
      if (o_done != 4'b0000 || o_err != 4'b0000) begin
         if (pq.size() == 0) begin
            check_val("spurious_pulse", {o_done, o_err}, 128'd0);
         end else begin
            e  = pq.pop_front();
            oh = 4'b0001 << e.ch;
            check_val("pulse", {o_done, o_err}, e.is_err ? {4'b0000, oh} : {oh, 4'b0000});
            if (e.is_err) exp_etype = e.etype;
            check_val("error_type", o_etype, exp_etype);
            check_val("run_len", last_run, e.run_len);
            check_val("release_resetn", o_resetn, 1'b0);
            check_val("release_grant", o_grant, 4'b0000);
            check_val("release_busy", o_busy, 1'b1);
            remaining[e.ch]--;
         end
      end
      drive_inputs();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) remaining[c] = 0;
      drive_inputs();
      cycle();
      check_val("rst_grant", o_grant, 4'b0000);
      check_val("rst_pulses", {o_done, o_err}, 8'h00);
      check_val("rst_etype", o_etype, 3'b000);
      check_val("rst_busy", o_busy, 1'b0);
      check_val("rst_resetn", o_resetn, 1'b0);
      check_val("rst_router", o_router, 4'b0000);
      check_val("rst_addr", o_addr, 128'd0);
      check_val("rst_len", o_len, 128'd0);
      exp_etype = 3'b000;
      rst = 1'b0;
   endtask

   task automatic push_job(input int ch, input bit is_err, input logic [2:0] et, input int rl);
      exp_t e;
      e.ch = ch; e.is_err = is_err; e.etype = et; e.run_len = rl;
      pq.push_back(e);
      gq.push_back(ch);
   endtask

   task automatic run_jobs(input int budget);
      bit fin;
      fin = 1'b0;
      drive_inputs();
      for (int n = 0; n < budget && !fin; n++) begin
         cycle();
         if (pq.size() == 0 && !o_busy) fin = 1'b1;
      end
      check_val("finished", fin, 1'b1);
      check_val("idle_grant", o_grant, 4'b0000);
      check_val("grants_consumed", gq.size(), 0);
   endtask

   initial begin
      bit hit;
      ch_addr[0] = 32'h0000_0A00; ch_len[0] = 32'd5;
      ch_addr[1] = 32'h0000_1000; ch_len[1] = 32'd16;
      ch_addr[2] = 32'h2222_0000; ch_len[2] = 32'd77;
      ch_addr[3] = 32'hDEAD_BEE0; ch_len[3] = 32'd1024;
      done_after = 0; err_after = 0; err_code = 3'b000;
      run_cnt = 0; last_run = 0; hold_cnt = 0; cyc = 0; fall_cyc = 0; cur_ch = 0;
      lat_check = 1'b0; gap_check = 1'b0; have_fall = 1'b0;
      prev_grant = 4'b0000; cur_exp = 4'b0000; exp_etype = 3'b000;
      req = 4'b0000; addr_bus = '0; len_bus = '0;
      rd_done = 1'b0; rd_err = 1'b0; rd_etype = 3'b000;
      rst = 1'b1;
      reset_dut();
      reset_dut();

      // Single job on channel 1, reader done after 40 cycles.
      done_after = 40;
      push_job(1, 1'b0, 3'b000, 40);
      remaining[1] = 1;
      lat_check = 1'b1;
      req_cyc = cyc;
      run_jobs(100);

      // All channels requesting: 0,1,2,3,0 with RELEASE+IDLE gaps.
      reset_dut();
      gap_check = 1'b1; have_fall = 1'b0;
      done_after = 8;
      push_job(0, 1'b0, 3'b000, 8);
      push_job(1, 1'b0, 3'b000, 8);
      push_job(2, 1'b0, 3'b000, 8);
      push_job(3, 1'b0, 3'b000, 8);
      push_job(0, 1'b0, 3'b000, 8);
      remaining[0] = 2; remaining[1] = 1; remaining[2] = 1; remaining[3] = 1;
      run_jobs(200);
      gap_check = 1'b0;

      // Reader error 010 on channel 2, then a normal job keeps the code.
      done_after = 0; err_after = 5; err_code = 3'b010;
      push_job(2, 1'b1, 3'b010, 5);
      remaining[2] = 1;
      run_jobs(60);
      done_after = 6; err_after = 0; err_code = 3'b000;
      push_job(3, 1'b0, 3'b000, 6);
      remaining[3] = 1;
      run_jobs(60);

      // Done and error together: error only.
      done_after = 7; err_after = 7; err_code = 3'b011;
      push_job(1, 1'b1, 3'b011, 7);
      remaining[1] = 1;
      run_jobs(60);

      // Reader never finishes: watchdog after 64 RUN cycles.
      done_after = 0; err_after = 0; err_code = 3'b000;
      push_job(0, 1'b1, 3'b110, WD);
      remaining[0] = 1;
      run_jobs(120);

      // Serve channel 0 so the pointer moves away from 3, then abort a job with reset.
      done_after = 4;
      push_job(0, 1'b0, 3'b000, 4);
      remaining[0] = 1;
      run_jobs(60);
      done_after = 0;
      gq.push_back(1);
      remaining[1] = 1;
      drive_inputs();
      hit = 1'b0;
      for (int n = 0; n < 60 && !hit; n++) begin
         cycle();
         if (run_cnt == 10) hit = 1'b1;
      end
      check_val("reached_run10", hit, 1'b1);
      reset_dut();
      cycle();
      check_val("post_rst_idle", {o_busy, o_grant}, 5'd0);
      done_after = 4;
      push_job(0, 1'b0, 3'b000, 4);
      push_job(3, 1'b0, 3'b000, 4);
      remaining[0] = 1; remaining[3] = 1;
      run_jobs(80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/painterengine_gpu_reader_scheduler.md
PAINTERENGINE_GPU_READER_SCHEDULER -- requirements
Module: painterengine_gpu_reader_scheduler

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: number of cycles o_wire_reader_resetn is held low before each job.
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 1048576: maximum number of RUN cycles per job.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: i_wire_clock and i_wire_reset.
REQ-004 SHALL have these ports:
- i_wire_clock  in  1  clock
- i_wire_reset  in  1  synchronous, active-high reset
- i_wire_request  in  4  per-channel job request (level)
- i_wire_address  in  128  per-channel base address, 32 bits each
- i_wire_length  in  128  per-channel word count, 32 bits each
- o_wire_grant  out  4  one-hot channel currently owning the reader
- o_wire_channel_done  out  4  one-cycle completion pulse
- o_wire_channel_error  out  4  one-cycle failure pulse
- o_wire_error_type  out  3  error code of the last failed job
- o_wire_busy  out  1  high outside IDLE
- o_wire_reader_resetn  out  1  active-low reset driven to the reader
- o_wire_router  out  4  one-hot router select to the reader
- o_wire_address  out  128  address bus to the reader
- o_wire_length  out  128  length bus to the reader
- i_wire_reader_done  in  1  reader done level
- i_wire_reader_error  in  1  reader error level
- i_wire_reader_error_type  in  3  reader error code

Function
REQ-005 SHALL implement four states: IDLE, HOLD, RUN, RELEASE.
REQ-006 IDLE: reader_resetn=0, router=0, grant=0; if i_wire_request!=0, SHALL latch the round-robin winner index and enter HOLD on the next edge.
REQ-007 Round robin: search starts at (last_served+1) mod 4; last_served resets to 3, so channel 0 wins first.
REQ-008 HOLD: grant and router equal the winner one-hot; reader_resetn=0 for exactly RESET_CYCLES cycles; then enter RUN.
REQ-009 RUN: reader_resetn=1; router and grant stay stable for the whole job, so the reader samples a valid router on its first post-reset cycle.
REQ-010 Only the granted channel's 32-bit address/length slice SHALL be driven on o_wire_address/o_wire_length; all other slices SHALL be zero; values SHALL be registered at the HOLD entry.
REQ-011 RUN, i_wire_reader_done=1: SHALL pulse channel_done[idx] for one cycle, set last_served=idx, and enter RELEASE.
REQ-012 RUN, i_wire_reader_error=1: SHALL pulse channel_error[idx], capture i_wire_reader_error_type into o_wire_error_type, and enter RELEASE; if done and error are both high, error wins.
REQ-013 RUN watchdog: a 21-bit counter SHALL clear on HOLD entry; when it reaches WATCHDOG_CYCLES, the block SHALL pulse channel_error[idx], set error_type=3'b110, and enter RELEASE.
REQ-014 RELEASE: reader_resetn=0, grant=0, router=0 for one cycle, then IDLE; this gives a minimum 1-cycle gap plus one IDLE cycle between jobs.
REQ-015 A requester SHALL hold its request until its done/error pulse; a request dropped mid-job is ignored and the job completes; a request still high in IDLE is treated as a new job.
REQ-016 Request-to-reader-release latency SHALL be 1 (IDLE) + RESET_CYCLES cycles.
REQ-017 o_wire_error_type SHALL hold its value until the next error; success does not clear it.

Reset
REQ-018 On i_wire_reset: state=IDLE, last_served=3, watchdog=0, every output=0 (including reader_resetn=0, which holds the reader in reset), error_type=3'b000.
REQ-019 Reset asserted mid-job SHALL abort the job without any done or error pulse.

Structure
REQ-020 A shared package SHALL hold the state encoding, the reader error codes (000-101), the scheduler timeout code 3'b110, and the channel count 4.
REQ-021 The combinational round-robin pick SHALL be the sub-module painterengine_gpu_rr_arbiter: inputs are the request and pointer, the output is the winner index and a valid flag.

Verification
REQ-022 Channel 1 requests addr 0x1000, len 16; reader done after 40 cycles -> router=4'b0010 held, resetn low 2 cycles, done[1] pulses once, error_type=000.
REQ-023 All four channels request continuously -> grants follow the order 0,1,2,3,0, each separated by a RELEASE+IDLE gap.
REQ-024 Reader raises error with type 010 on channel 2 -> error[2] pulses, error_type=010, and the next job proceeds normally.
REQ-025 Done and error rise in the same cycle -> only error[idx] pulses.
REQ-026 WATCHDOG_CYCLES=64 and the reader never finishes -> error[idx] pulses at RUN cycle 64, error_type=110, reader_resetn returns low.
REQ-027 i_wire_reset is asserted in RUN cycle 10 -> all outputs are 0 next cycle, with no pulses, and channel 0 is granted first afterwards.
